// File: rtl/addr_rf_pkg.sv
// Shared types for the AddrToRF sequencer: FSM state enum, job descriptor, coordinate widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// HW/LW come from the IA_ROW / W_C_LENGTH macros of header.h; fallbacks below keep a bare build complete.
`ifndef IA_ROW
`define IA_ROW 16
`endif
`ifndef W_C_LENGTH
`define W_C_LENGTH 32
`endif

package addr_rf_pkg;

    localparam int HW = $clog2(`IA_ROW) + 1;
    localparam int LW = $clog2(`W_C_LENGTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HAND,
        DONE
    } sched_state_e;

    typedef struct packed {
        logic [HW-1:0] rows;
        logic [HW-1:0] cols;
        logic [1:0]    stride;
        logic [LW-1:0] length;
    } job_desc_t;

    // A stride of 0 means "unit stride".
    function automatic logic [1:0] eff_stride(input logic [1:0] s);
        return (s == 2'd0) ? 2'd1 : s;
    endfunction

endpackage

// File: rtl/addr_rf_scheduler_anchor_counter.sv
// Raster (h, w) anchor stepper with stride, end-of-row wrap and last-anchor detection.
// Latency: new anchor visible the cycle after i_step; o_last is combinational on the current anchor.
// Backpressure: none; steps only when the owner pulses i_step.
// Ports: i_clk/i_rst, i_clear (back to (0,0)), i_step (advance), i_s/i_rows/i_cols (job geometry),
//        o_h/o_w (current anchor), o_last (stepping now would leave the activation).
module anchor_counter #(
    parameter int HW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_step,
    input  logic [1:0]    i_s,
    input  logic [HW-1:0] i_rows,
    input  logic [HW-1:0] i_cols,
    output logic [HW-1:0] o_h,
    output logic [HW-1:0] o_w,
    output logic          o_last
);

    localparam int HW1 = HW + 1;

    // One extra bit so w+s / h+s never wrap around before the compare.
    logic [HW:0] w_nx;
    logic [HW:0] h_nx;
    logic        wrap;

    assign w_nx   = {1'b0, o_w} + HW1'(i_s);
    assign h_nx   = {1'b0, o_h} + HW1'(i_s);
    assign wrap   = (w_nx >= {1'b0, i_cols});
    assign o_last = wrap && (h_nx >= {1'b0, i_rows});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_h <= '0;
            o_w <= '0;
        end else if (i_clear) begin
            o_h <= '0;
            o_w <= '0;
        end else if (i_step) begin
            if (wrap) begin
                o_w <= '0;
                o_h <= h_nx[HW-1:0];
            end else begin
                o_w <= w_nx[HW-1:0];
            end
        end
    end

endmodule

// File: rtl/addr_rf_scheduler.sv
// Job sequencer for AddrToRF: walks every output anchor in raster order, one launch/finish/hand-off per anchor.
// Latency: first launch the cycle after job accept; >= 3 cycles per anchor (ISSUE, WAIT, HAND).
// Backpressure: holds o_rf_valid and the anchor until i_rf_ready; i_start ignored while busy.
// Ports: i_start/i_rows/i_cols/i_stride/i_length (job in), o_busy/o_done (job status),
//        o_ar_* / i_ar_finish (AddrToRF control), o_rf_valid/i_rf_ready (PE hand-off), o_tile_cnt.
// Option: define ADDR_RF_SCHED_TIMEOUT_EN for a WAIT watchdog of TIMEOUT_CYC cycles and the sticky o_err port.
`ifndef IA_ROW
`define IA_ROW 16
`endif
`ifndef W_C_LENGTH
`define W_C_LENGTH 32
`endif

module addr_rf_scheduler #(
    parameter int  IA_ROW      = `IA_ROW,
    parameter int  W_C_LENGTH  = `W_C_LENGTH,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int HW          = $clog2(IA_ROW) + 1,
    localparam int LW          = $clog2(W_C_LENGTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [HW-1:0]   i_rows,
    input  logic [HW-1:0]   i_cols,
    input  logic [1:0]      i_stride,
    input  logic [LW-1:0]   i_length,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_ar_start,
    output logic [HW-1:0]   o_ar_h,
    output logic [HW-1:0]   o_ar_w,
    output logic [1:0]      o_ar_s,
    output logic [LW-1:0]   o_ar_length,
    input  logic            i_ar_finish,
    output logic            o_rf_valid,
    input  logic            i_rf_ready,
    output logic [2*HW-1:0] o_tile_cnt
`ifdef ADDR_RF_SCHED_TIMEOUT_EN
    ,
    output logic            o_err
`endif
);

    import addr_rf_pkg::*;

    sched_state_e state;
    sched_state_e state_nx;
    job_desc_t    job;
    logic         accept;
    logic         hand_fire;
    logic         last_anchor;
    logic         wdog_hit;

    assign accept    = (state == IDLE) && i_start;
    assign hand_fire = (state == HAND) && i_rf_ready;

    assign o_ar_s      = job.stride;
    assign o_ar_length = job.length;

    anchor_counter #(.HW(HW)) u_anchor (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (accept),
        .i_step  (hand_fire),
        .i_s     (job.stride),
        .i_rows  (job.rows),
        .i_cols  (job.cols),
        .o_h     (o_ar_h),
        .o_w     (o_ar_w),
        .o_last  (last_anchor)
    );

`ifdef ADDR_RF_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wdog_cnt;

    // Fires on the TIMEOUT_CYC-th WAIT cycle that still has no finish.
    assign wdog_hit = (state == WAIT) && !i_ar_finish && (wdog_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            wdog_cnt <= (state == WAIT) ? wdog_cnt + 1'b1 : '0;
            if (wdog_hit) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
    // The watchdog limit only matters when the watchdog is compiled in.
    if (TIMEOUT_CYC < 1) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            job        <= '0;
            o_tile_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                job.rows   <= i_rows;
                job.cols   <= i_cols;
                job.stride <= eff_stride(i_stride);
                job.length <= i_length;
                o_tile_cnt <= '0;
            end else if (hand_fire) begin
                o_tile_cnt <= o_tile_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        o_busy     = 1'b1;
        o_ar_start = 1'b0;
        o_rf_valid = 1'b0;
        o_done     = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nx = (i_rows == '0 || i_cols == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                o_ar_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (i_ar_finish) begin
                    state_nx = HAND;
                end else if (wdog_hit) begin
                    state_nx = DONE;
                end
            end
            HAND: begin
                o_rf_valid = 1'b1;
                if (i_rf_ready) begin
                    state_nx = last_anchor ? DONE : ISSUE;
                end
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_addr_rf_scheduler.sv
// Randomized bench for addr_rf_scheduler against a spec-level anchor list and protocol model.
// Latency: n/a (testbench).
// Backpressure: drives i_rf_ready with fixed, random or held-low patterns.
module tb_addr_rf_scheduler;

    localparam int HW = addr_rf_pkg::HW;
    localparam int LW = addr_rf_pkg::LW;

    localparam int P_ISSUE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_HAND  = 2;
    localparam int P_DONE  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [HW-1:0]   rows = '0;
    logic [HW-1:0]   cols = '0;
    logic [1:0]      stride = '0;
    logic [LW-1:0]   length = '0;
    logic            busy, done, ar_start, rf_valid;
    logic [HW-1:0]   ar_h, ar_w;
    logic [1:0]      ar_s;
    logic [LW-1:0]   ar_length;
    logic            ar_finish = 1'b0;
    logic            rf_ready = 1'b0;
    logic [2*HW-1:0] tile_cnt;
`ifdef ADDR_RF_SCHED_TIMEOUT_EN
    logic            err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    addr_rf_scheduler #(.TIMEOUT_CYC(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_rows      (rows),
        .i_cols      (cols),
        .i_stride    (stride),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done),
        .o_ar_start  (ar_start),
        .o_ar_h      (ar_h),
        .o_ar_w      (ar_w),
        .o_ar_s      (ar_s),
        .o_ar_length (ar_length),
        .i_ar_finish (ar_finish),
        .o_rf_valid  (rf_valid),
        .i_rf_ready  (rf_ready),
        .o_tile_cnt  (tile_cnt)
`ifdef ADDR_RF_SCHED_TIMEOUT_EN
        ,
        .o_err       (err)
`endif
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic longint all_outs();
        return longint'({busy, done, ar_start, rf_valid, ar_h, ar_w, ar_s, ar_length, tile_cnt});
    endfunction

    // rdy_mode: 0 ready always high, 1 random, 2 first hand-off held low 7 cycles.
    // abort_at: reset in the first WAIT cycle of that launch (0 = never).
    // withhold: never return finish (watchdog job).
    task automatic run_job(input int r, input int c, input int s, input int l,
                           input int dly_lo, input int dly_hi, input int rdy_mode,
                           input int abort_at, input bit withhold);
        int es, n_exp, phase, dly, cur_h, cur_w, launches, hands, hold, wcnt;
        int exp_h[$];
        int exp_w[$];
        es = (s == 0) ? 1 : s;
        for (int h = 0; h < r; h += es)
            for (int w = 0; w < c; w += es) begin
                exp_h.push_back(h);
                exp_w.push_back(w);
            end
        n_exp = exp_h.size();
        launches = 0; hands = 0; hold = 0; wcnt = 0; dly = 0; cur_h = 0; cur_w = 0;

        @(negedge clk);
        rows = HW'(r); cols = HW'(c); stride = 2'(s); length = LW'(l); start = 1'b1;
        @(posedge clk); #1;
        rows = HW'($urandom); cols = HW'($urandom); stride = 2'($urandom); length = LW'($urandom);
        phase = (n_exp == 0) ? P_DONE : P_ISSUE;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("ctl", {ar_start, rf_valid, done, busy},
                  {phase == P_ISSUE, phase == P_HAND, phase == P_DONE, 1'b1});
            ar_finish = 1'b0;
            rf_ready  = 1'b0;
            start     = (phase != P_DONE) && ($urandom_range(0, 5) == 0);
            case (phase)
                P_ISSUE: begin
                    check("anchor_h", ar_h, exp_h[0]);
                    check("anchor_w", ar_w, exp_w[0]);
                    check("ar_s", ar_s, es);
                    check("ar_len", ar_length, l);
                    cur_h = exp_h.pop_front();
                    cur_w = exp_w.pop_front();
                    launches++;
                    dly  = $urandom_range(dly_lo, dly_hi);
                    wcnt = 0;
                    ar_finish = ($urandom_range(0, 3) == 0);
                    phase = P_WAIT;
                end
                P_WAIT: begin
                    wcnt++;
                    if (launches == abort_at) begin
                        start = 1'b0;
                        rst = 1'b1;
                        #1;
                        check("rst_outs", all_outs(), 0);
                        @(negedge clk);
                        rst = 1'b0;
                        return;
                    end
                    if (withhold) begin
                        if (wcnt == 16) phase = P_DONE;
                    end else if (dly == 0) begin
                        ar_finish = 1'b1;
                        phase = P_HAND;
                    end else begin
                        dly--;
                    end
                end
                P_HAND: begin
                    check("hold_h", ar_h, cur_h);
                    check("hold_w", ar_w, cur_w);
                    check("tile_cnt", tile_cnt, hands);
                    if (rdy_mode == 2 && hands == 0 && hold < 7) begin
                        hold++;
                        start = 1'b1;
                        ar_finish = 1'b1;
                    end else begin
                        rf_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                        ar_finish = ($urandom_range(0, 3) == 0);
                    end
                    if (rf_ready) begin
                        hands++;
                        phase = (exp_h.size() == 0) ? P_DONE : P_ISSUE;
                    end
                end
                default: begin
                    check("tile_end", tile_cnt, withhold ? 0 : n_exp);
                    check("launches", launches, withhold ? 1 : n_exp);
                    check("handoffs", hands, withhold ? 0 : n_exp);
`ifdef ADDR_RF_SCHED_TIMEOUT_EN
                    check("err", err, withhold);
`endif
                    @(posedge clk); #1;
                    check("idle", {busy, done, ar_start, rf_valid}, 0);
                    return;
                end
            endcase
            @(posedge clk); #1;
        end
        check("job_end", phase, P_DONE);
    endtask

    initial begin
        #1;
        check("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", all_outs(), 0);

        run_job(4, 4, 1, 9, 4, 4, 0, 0, 1'b0);
        run_job(10, 11, 2, 21, 0, 3, 1, 0, 1'b0);
        run_job(2, 3, 0, 5, 0, 2, 1, 0, 1'b0);
        run_job(0, 5, 1, 3, 0, 0, 0, 0, 1'b0);
        run_job(3, 0, 2, 3, 0, 0, 0, 0, 1'b0);
        run_job(3, 3, 1, 7, 0, 2, 2, 0, 1'b0);
        run_job(4, 4, 1, 1, 1, 3, 0, 3, 1'b0);
        run_job(4, 4, 1, 2, 0, 2, 1, 0, 1'b0);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3),
                    $urandom_range(0, (1 << LW) - 1), 0, 3, 1, 0, 1'b0);
        run_job(15, 15, 3, 11, 0, 1, 0, 0, 1'b0);
`ifdef ADDR_RF_SCHED_TIMEOUT_EN
        run_job(2, 2, 1, 4, 0, 0, 0, 0, 1'b1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
